// File: rtl/systolic_pkg.sv
// Shared types and width helpers for the systolic tile sequencer.
package systolic_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StCompute,
    StDrain,
    StDone
  } state_t;

  // Row-index width; a single-row array still needs one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  // Compute counter must reach K+N+M-2 without wrapping.
  function automatic int unsigned calc_cw(input int unsigned kw, input int unsigned n,
                                          input int unsigned m);
    return kw + $clog2(n + m) + 1;
  endfunction

endpackage

// File: rtl/skew_window_gen.sv
// Per-lane feed window: lane l is enabled while l <= t < l+K.
module skew_window_gen #(
  parameter int unsigned LANES = 2,
  parameter int unsigned CW    = 8
) (
  input  logic [CW-1:0]    i_t,
  input  logic [CW-1:0]    i_k,
  input  logic             i_active,
  output logic [LANES-1:0] o_en
);

  // t < l wraps t-l to a value far above any K, so one compare covers both bounds.
  always_comb begin
    o_en = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      o_en[l] = i_active && ((i_t - CW'(l)) < i_k);
    end
  end

endmodule

// File: rtl/systolic_tile_sequencer.sv
// Sequences one tile through the N x M systolic array: clear, skewed feed, drain, done.
module systolic_tile_sequencer
  import systolic_pkg::*;
#(
  parameter  int unsigned N  = 2,
  parameter  int unsigned M  = 2,
  parameter  int unsigned KW = 8,
  localparam int unsigned CW = calc_cw(KW, N, M),
  localparam int unsigned RW = clog2_min1(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [KW-1:0] i_k_len,
  input  logic          i_stall,
  input  logic          i_out_ready,
  output logic          o_busy,
  output logic          o_acc_clr,
  output logic [N-1:0]  o_a_row_en,
  output logic [M-1:0]  o_b_col_en,
  output logic          o_pe_en,
  output logic          o_out_valid,
  output logic [RW-1:0] o_out_row,
  output logic          o_done
);

  state_t        r_state;
  logic [CW-1:0] r_t;
  logic [KW-1:0] r_k;
  logic [RW-1:0] r_row;

  logic [CW-1:0] w_k_ext;
  logic [CW-1:0] w_t_last;
  logic          w_feed;

  assign w_k_ext  = CW'(r_k);
  // K >= 1 in COMPUTE, so K+N+M-3 never goes negative despite the subtraction.
  assign w_t_last = w_k_ext + CW'(N + M) - CW'(3);
  assign w_feed   = (r_state == StCompute) && !i_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_t     <= '0;
      r_k     <= '0;
      r_row   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            if (i_k_len != '0) begin
              r_k     <= i_k_len;
              r_state <= StClear;
            end else begin
              r_state <= StDone;
            end
          end
        end
        StClear: begin
          r_t     <= '0;
          r_state <= StCompute;
        end
        StCompute: begin
          if (!i_stall) begin
            r_t <= r_t + CW'(1);
            if (r_t == w_t_last) begin
              r_row   <= '0;
              r_state <= StDrain;
            end
          end
        end
        StDrain: begin
          if (i_out_ready) begin
            if (r_row == RW'(N - 1)) begin
              r_state <= StDone;
            end else begin
              r_row <= r_row + RW'(1);
            end
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy      = (r_state != StIdle);
  assign o_acc_clr   = (r_state == StClear);
  assign o_pe_en     = w_feed;
  assign o_out_valid = (r_state == StDrain);
  assign o_out_row   = (r_state == StDrain) ? r_row : '0;
  assign o_done      = (r_state == StDone);

  skew_window_gen #(
    .LANES(N),
    .CW   (CW)
  ) u_a_window (
    .i_t     (r_t),
    .i_k     (w_k_ext),
    .i_active(w_feed),
    .o_en    (o_a_row_en)
  );

  skew_window_gen #(
    .LANES(M),
    .CW   (CW)
  ) u_b_window (
    .i_t     (r_t),
    .i_k     (w_k_ext),
    .i_active(w_feed),
    .o_en    (o_b_col_en)
  );

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Drives a 2x2 and a 4x2 sequencer with shared stimulus and checks both against a trace model.
module tb_systolic_tile_sequencer;

  localparam int L = 64;

  typedef logic [12:0] obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] k_len = '0;
  logic       stall = 1'b0;
  logic       out_ready = 1'b1;

  logic       busy2, clr2, pe2, v2, done2;
  logic [1:0] a2, b2;
  logic [0:0] row2;
  logic       busy4, clr4, pe4, v4, done4;
  logic [3:0] a4;
  logic [1:0] b4, row4;

  logic [L-1:0] stall_v;
  logic [L-1:0] ready_v;
  obs_t         exp_q [2][L];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  systolic_tile_sequencer #(.N(2), .M(2), .KW(8)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .i_start    (start),
    .i_k_len    (k_len),
    .i_stall    (stall),
    .i_out_ready(out_ready),
    .o_busy     (busy2),
    .o_acc_clr  (clr2),
    .o_a_row_en (a2),
    .o_b_col_en (b2),
    .o_pe_en    (pe2),
    .o_out_valid(v2),
    .o_out_row  (row2),
    .o_done     (done2)
  );

  systolic_tile_sequencer #(.N(4), .M(2), .KW(8)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .i_start    (start),
    .i_k_len    (k_len),
    .i_stall    (stall),
    .i_out_ready(out_ready),
    .o_busy     (busy4),
    .o_acc_clr  (clr4),
    .o_a_row_en (a4),
    .o_b_col_en (b4),
    .o_pe_en    (pe4),
    .o_out_valid(v4),
    .o_out_row  (row4),
    .o_done     (done4)
  );

  function automatic obs_t mk(input logic busy, input logic clr, input logic pe,
                              input logic [3:0] a, input logic [1:0] b, input logic v,
                              input logic [1:0] row, input logic done);
    return {busy, clr, pe, a, b, v, row, done};
  endfunction

  // Expected per-cycle outputs for a tile started in cycle 0; rc >= 0 means rst in cycle rc.
  task automatic build(input int cfg, input int n, input int m, input int k, input int rc);
    int c, adv, row;
    logic [3:0] a;
    logic [1:0] b;
    for (int i = 0; i < L; i++) exp_q[cfg][i] = '0;
    c = 1;
    if (k != 0) begin
      exp_q[cfg][c] = mk(1, 1, 0, 0, 0, 0, 0, 0);
      c++;
      adv = 0;
      while (adv < k + n + m - 2 && c < L) begin
        if (stall_v[c]) begin
          exp_q[cfg][c] = mk(1, 0, 0, 0, 0, 0, 0, 0);
        end else begin
          a = '0;
          b = '0;
          for (int i = 0; i < n; i++) if (adv >= i && adv < i + k) a[i] = 1'b1;
          for (int j = 0; j < m; j++) if (adv >= j && adv < j + k) b[j] = 1'b1;
          exp_q[cfg][c] = mk(1, 0, 1, a, b, 0, 0, 0);
          adv++;
        end
        c++;
      end
      row = 0;
      while (row < n && c < L) begin
        exp_q[cfg][c] = mk(1, 0, 0, 0, 0, 1, 2'(row), 0);
        if (ready_v[c]) row++;
        c++;
      end
    end
    if (c < L) exp_q[cfg][c] = mk(1, 0, 0, 0, 0, 0, 0, 1);
    if (rc >= 0) for (int i = rc + 1; i < L; i++) exp_q[cfg][i] = '0;
  endtask

  task automatic check_pair(input string tag, input int c, input obs_t e2, input obs_t e4);
    obs_t o2, o4;
    o2 = mk(busy2, clr2, pe2, {2'b00, a2}, b2, v2, {1'b0, row2}, done2);
    o4 = mk(busy4, clr4, pe4, a4, b4, v4, row4, done4);
    checks++;
    assert (o2 === e2) else begin
      errors++;
      $error("FAIL %s n2m2 cycle %0d observed=%h expected=%h", tag, c, o2, e2);
    end
    checks++;
    assert (o4 === e4) else begin
      errors++;
      $error("FAIL %s n4m2 cycle %0d observed=%h expected=%h", tag, c, o4, e4);
    end
  endtask

  task automatic run(input string tag, input int k, input int s2, input int rc);
    build(0, 2, 2, k, rc);
    build(1, 4, 2, k, rc);
    for (int c = 0; c < L; c++) begin
      @(posedge clk);
      #1;
      rst       = (c == rc);
      start     = (c == 0) || (c == s2);
      k_len     = (c == 0) ? 8'(k) : 8'($urandom_range(1, 255));
      stall     = stall_v[c];
      out_ready = ready_v[c];
      #1;
      check_pair(tag, c, exp_q[0][c], exp_q[1][c]);
    end
    rst   = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_pair("reset", 0, '0, '0);
    rst = 1'b0;

    stall_v = '0;
    ready_v = '1;
    run("basic_k3", 3, -1, -1);

    stall_v[3] = 1'b1;
    stall_v[4] = 1'b1;
    run("stall_k3", 3, -1, -1);

    stall_v = '0;
    run("k_zero", 0, -1, -1);
    run("k_one", 1, -1, -1);

    ready_v[9:7] = 3'b000;
    run("ready_hold", 3, 8, -1);

    ready_v = '1;
    run("rst_mid", 3, -1, 4);
    run("after_rst", 3, -1, -1);

    for (int it = 0; it < 10; it++) begin
      stall_v = {$urandom, $urandom} & {$urandom, $urandom} & 64'h0000_0000_00FF_FFFF;
      ready_v = ~({$urandom, $urandom} & {$urandom, $urandom} & 64'h0000_00FF_FFFF_FFFF);
      run("random", $urandom_range(1, 6), $urandom_range(2, 4), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_tile_sequencer.md
Name: systolic_tile_sequencer

Overview:
Sequences one matrix tile through the N x M systolic PE array. It accepts a start/k_len command, clears the PE accumulators, and drives skewed per-row A and per-column B feed enables for K inner-dimension steps. It then lets the wavefront drain through the array and hands results out row by row under a valid/ready handshake. It sits between the host command interface and the array/feeder buffers.

Parameters:
N, 2, number of PE rows (A feed lanes); N >= 1
M, 2, number of PE columns (B feed lanes); M >= 1
KW, 8, width of k_len
CW (localparam), KW + $clog2(N+M) + 1, width of compute counter t
RW (localparam), max(1, $clog2(N)), width of out_row

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  command strobe; honoured only in IDLE
k_len  in  KW  inner dimension K; sampled when start is accepted
stall  in  1  feeder data not available; freezes COMPUTE
out_ready  in  1  result consumer ready
busy  out  1  high whenever state != IDLE
acc_clr  out  1  one-cycle accumulator clear pulse
a_row_en  out  N  bit i feeds row i this cycle
b_col_en  out  M  bit j feeds column j this cycle
pe_en  out  1  array advance enable
out_valid  out  1  result row available
out_row  out  RW  index of the row being presented
done  out  1  one-cycle tile-complete pulse

Behaviour:
- Reset: synchronous, active-high; all outputs are 0; state = IDLE; t = 0; r = 0; K latch = 0.
- rst asserted in any state returns to IDLE on the next edge. No done pulse is issued.
- States: IDLE, CLEAR, COMPUTE, DRAIN, DONE (registered state, one-hot or binary).
- IDLE:
  - start && k_len != 0: latch K, go to CLEAR.
  - start && k_len == 0: go to DONE. No acc_clr, no feeds.
- CLEAR: acc_clr = 1 for exactly this one cycle; t <= 0; go to COMPUTE. stall is ignored.
- COMPUTE:
  - !stall: pe_en = 1; a_row_en[i] = (t >= i && t < i+K); b_col_en[j] = (t >= j && t < j+K); t <= t+1.
  - stall: pe_en = 0; a_row_en = 0; b_col_en = 0; t holds.
  - Exit: when t == K+N+M-3 && !stall, go to DRAIN with r <= 0. This gives exactly K+N+M-2 advancing cycles.
  - Counter arithmetic is unsigned CW-bit, with no overflow for max K.
- DRAIN:
  - out_valid = 1; out_row = r.
  - On out_valid && out_ready: if r == N-1, go to DONE; else r <= r+1.
  - out_row is stable while out_ready is low. stall is ignored.
- DONE: done = 1 for one cycle; go to IDLE.
- start while busy is ignored and not queued.
- All outputs are driven from registered state/counters through combinational decode. Zero-stall latency is: start edge, then CLEAR next cycle.

Decomposition:
- Shared package systolic_pkg:
  - state typedef (IDLE/CLEAR/COMPUTE/DRAIN/DONE)
  - width helper function for CW/RW
- One sub-module, skew_window_gen #(LANES, CW):
  - inputs t, K, active
  - output LANES-bit vector, bit l = active && t >= l && t < l+K
  - instantiated twice: LANES=N for A, LANES=M for B.

Test Plan:
1. N=M=2, K=3, stall=0, out_ready=1, start in cycle 0:
   - acc_clr in cycle 1.
   - COMPUTE cycles 2-6: a_row_en/b_col_en = 01, 11, 11, 10, 00.
   - pe_en high in cycles 2-6.
   - out_valid with out_row 0 in cycle 7 and 1 in cycle 8.
   - done in cycle 9; busy high in cycles 1-9.
2. Same as scenario 1 with stall high in cycles 3-4:
   - Enables are 0 and t is frozen during the stall.
   - Enable sequence resumes 11, 11, 10, 00; done in cycle 11.
3. k_len=0 start:
   - No acc_clr, no pe_en.
   - done in the cycle after start; busy high for one cycle.
4. N=4, M=2, K=1:
   - 5 COMPUTE cycles.
   - a_row_en = 0001, 0010, 0100, 1000, 0000.
   - b_col_en = 01, 10, 00, 00, 00.
   - 4 DRAIN rows 0-3.
5. out_ready low for 3 cycles in DRAIN:
   - out_row holds; no advance.
   - Second start pulsed during this window is ignored (no new acc_clr after done).
6. rst asserted mid-COMPUTE (t=2):
   - All outputs 0 on the next cycle; no done.
   - A fresh start then runs scenario 1 timing exactly.
